// File: rtl/i3c_ahb_if_pkg.sv
// Shared definitions for the I3C AHB-to-CSR bridge: width constants, AHB encodings, bridge state.
// Latency: n/a (package).
// Backpressure: n/a (package).
package i3c_ahb_if_pkg;

   localparam int CSR_DW = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

   // Low address bits that must be zero for a transfer of the given size.
   function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      case (size)
         HSIZE_HALF: return addr_lo[0];
         HSIZE_WORD: return |addr_lo;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/i3c_ahb_lane_ctrl.sv
// Selects the 32-bit write lane from the AHB write bus and builds CSR bit enables from size/address.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
// Ports: hsize_i/addr_i = captured transfer size and low address bits, hwdata_i = AHB write bus,
//        wr_data_o = selected 32-bit lane, wr_biten_o = per-bit write enables.
module i3c_ahb_lane_ctrl
   import i3c_ahb_if_pkg::*;
#(
   parameter int AHB_DATA_WIDTH = 64,
   parameter int LANE_ADDR_W    = $clog2(AHB_DATA_WIDTH / 8)
) (
   input  logic [2:0]                hsize_i,
   input  logic [LANE_ADDR_W-1:0]    addr_i,
   input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
   output logic [CSR_DW-1:0]         wr_data_o,
   output logic [CSR_DW-1:0]         wr_biten_o
);

   generate
      if (AHB_DATA_WIDTH == CSR_DW) begin : g_one_lane
         assign wr_data_o = hwdata_i;
      end else begin : g_lane_mux
         // Address bits above the word offset pick which 32-bit slice of hwdata carries the data.
         logic [LANE_ADDR_W-3:0] lane;
         assign lane      = addr_i[LANE_ADDR_W-1:2];
         assign wr_data_o = hwdata_i[{lane, 5'd0} +: CSR_DW];
      end
   endgenerate

   always_comb begin
      wr_biten_o = '1;
      case (hsize_i)
         HSIZE_BYTE: wr_biten_o = 32'h0000_00FF << {addr_i[1:0], 3'b000};
         HSIZE_HALF: wr_biten_o = 32'h0000_FFFF << {addr_i[1:0], 3'b000};
         default:    wr_biten_o = '1;
      endcase
   end

endmodule

// File: rtl/i3c_ahb_csr_bridge.sv
// AHB-Lite subordinate turning each AHB transfer into one CSR (s_cpuif) request for the I3C block.
// Latency: min 1 wait state (request in first data cycle, OKAY next cycle if ack is immediate).
// Backpressure: stall_wr/stall_rd hold the request; AHB wait states are inserted until the CSR ack.
// Ports: AHB side hsel/haddr/hsize/htrans/hwrite/hwdata/hready in, hrdata/hreadyout/hresp out;
//        CSR side s_cpuif_req/_req_is_wr/_addr/_wr_data/_wr_biten out, stalls, acks, errs, rd_data in.
// Option: define I3C_AHB_BRIDGE_TIMEOUT_EN to add an ack watchdog of TIMEOUT_CYCLES cycles.
module i3c_ahb_csr_bridge
   import i3c_ahb_if_pkg::*;
#(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int AHB_DATA_WIDTH = 64,
   parameter int CSR_ADDR_WIDTH = 12,
   parameter int CSR_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      hclk_i,
   input  logic                      hreset_n_i,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  logic [2:0]                hsize,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic [AHB_DATA_WIDTH-1:0] hwdata,
   input  logic                      hsel,
   input  logic                      hready,
   output logic [AHB_DATA_WIDTH-1:0] hrdata,
   output logic                      hreadyout,
   output logic                      hresp,
   output logic                      s_cpuif_req,
   output logic                      s_cpuif_req_is_wr,
   output logic [CSR_ADDR_WIDTH-1:0] s_cpuif_addr,
   output logic [CSR_DATA_WIDTH-1:0] s_cpuif_wr_data,
   output logic [CSR_DATA_WIDTH-1:0] s_cpuif_wr_biten,
   input  logic                      s_cpuif_req_stall_wr,
   input  logic                      s_cpuif_req_stall_rd,
   input  logic                      s_cpuif_rd_ack,
   input  logic                      s_cpuif_rd_err,
   input  logic [CSR_DATA_WIDTH-1:0] s_cpuif_rd_data,
   input  logic                      s_cpuif_wr_ack,
   input  logic                      s_cpuif_wr_err
);

   bridge_state_e             state_q, state_d;
   logic [CSR_ADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic                      hwrite_q, hwrite_d;
   logic [2:0]                hsize_q, hsize_d;
   logic [CSR_DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   logic accept;
   logic out_of_window;
   logic acc_err;
   logic req_go;
   logic ack_m;
   logic err_m;
   logic tmo_hit;

   assign hreadyout = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
   assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

   assign accept = hsel && hready && hreadyout &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

   generate
      if (AHB_ADDR_WIDTH > CSR_ADDR_WIDTH) begin : g_window
         assign out_of_window = |haddr[AHB_ADDR_WIDTH-1:CSR_ADDR_WIDTH];
      end else begin : g_no_window
         assign out_of_window = 1'b0;
      end
   endgenerate

   assign acc_err = (hsize > HSIZE_WORD) || size_misaligned(hsize, haddr[1:0]) || out_of_window;

   // Only the ack/err of the direction in flight counts; the other direction is ignored.
   assign req_go = !(hwrite_q ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd);
   assign ack_m  = hwrite_q ? s_cpuif_wr_ack : s_cpuif_rd_ack;
   assign err_m  = hwrite_q ? s_cpuif_wr_err : s_cpuif_rd_err;

   always_comb begin
      state_d     = state_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      rd_data_d   = rd_data_q;
      s_cpuif_req = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (accept) begin
               haddr_d  = haddr[CSR_ADDR_WIDTH-1:0];
               hwrite_d = hwrite;
               hsize_d  = hsize;
               state_d  = acc_err ? ST_ERR1 : ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            s_cpuif_req = req_go;
            if (req_go && ack_m) begin
               state_d = err_m ? ST_ERR1 : ST_DONE;
               if (!hwrite_q && !err_m) rd_data_d = s_cpuif_rd_data;
            end else if (tmo_hit) begin
               state_d = ST_ERR1;
            end else if (req_go) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ack_m) begin
               state_d = err_m ? ST_ERR1 : ST_DONE;
               if (!hwrite_q && !err_m) rd_data_d = s_cpuif_rd_data;
            end else if (tmo_hit) begin
               state_d = ST_ERR1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef I3C_AHB_BRIDGE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Counts every cycle spent in REQ or WAIT, restarting on each new entry to REQ.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
         tmo_cnt_d = '0;
      end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
   end

   always_ff @(posedge hclk_i or negedge hreset_n_i) begin
      if (!hreset_n_i) tmo_cnt_q <= '0;
      else             tmo_cnt_q <= tmo_cnt_d;
   end

   assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge hclk_i or negedge hreset_n_i) begin
      if (!hreset_n_i) begin
         state_q   <= ST_IDLE;
         haddr_q   <= '0;
         hwrite_q  <= 1'b0;
         hsize_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         haddr_q   <= haddr_d;
         hwrite_q  <= hwrite_d;
         hsize_q   <= hsize_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign hrdata            = {(AHB_DATA_WIDTH / CSR_DATA_WIDTH){rd_data_q}};
   assign s_cpuif_req_is_wr = hwrite_q;
   assign s_cpuif_addr      = {haddr_q[CSR_ADDR_WIDTH-1:2], 2'b00};

   i3c_ahb_lane_ctrl #(
      .AHB_DATA_WIDTH (AHB_DATA_WIDTH)
   ) u_lane_ctrl (
      .hsize_i    (hsize_q),
      .addr_i     (haddr_q[$clog2(AHB_DATA_WIDTH/8)-1:0]),
      .hwdata_i   (hwdata),
      .wr_data_o  (s_cpuif_wr_data),
      .wr_biten_o (s_cpuif_wr_biten)
   );

endmodule
